pulse_stretcher: RTL and testbench

// Converts single-cycle pulses (e.g. from the edge-to-pulse input FSM) back into
// a level held high for a fixed number of cycles. A cooldown gap follows each level.

---
 rtl/pulse_stretcher_pkg.sv | 18 +
 rtl/ps_load_counter.sv | 30 +++
 rtl/pulse_stretcher.sv | 135 +++++++++++++
 tb/tb_pulse_stretcher.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } ps_state_t;

  // Counter width able to hold the larger of the hold and gap lengths.
  function automatic int unsigned ps_cnt_width(input int unsigned hold_cycles,
                                               input int unsigned gap_cycles);
    int unsigned max_c;
    max_c = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (max_c < 1) ? 1 : $clog2(max_c + 1);
  endfunction

endpackage

// File: rtl/ps_load_counter.sv
// Loadable down-counter; load has priority over decrement.
module ps_load_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: reload or step down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle request pulses into a HOLD_CYCLES-wide level followed
// by a GAP_CYCLES cooldown. Pulses that cannot be accepted raise dropped.
// Optional build macro: PULSE_STRETCHER_RETRIGGER_EN (pulses during the hold
// reload the hold counter instead of being dropped).
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy,
  output logic dropped
);

  localparam int unsigned CNT_W     = ps_cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned HOLD_LOAD = HOLD_CYCLES - 1;
  localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam logic RETRIGGER = 1'b1;
`else
  localparam logic RETRIGGER = 1'b0;
`endif

  ps_state_t        state_q;
  logic             out_q;
  logic             busy_q;
  logic             dropped_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  ps_load_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Counter control: load on entry to HOLD/GAP or retrigger, else count down.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(HOLD_LOAD);
        end
      end
      HOLD: begin
        if (RETRIGGER && in) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(HOLD_LOAD);
        end else if (cnt != '0) begin
          cnt_en = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(GAP_LOAD);
        end
      end
      GAP: begin
        cnt_en = (cnt != '0);
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // State and registered outputs; dropped is a one-cycle flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in) begin
            state_q <= HOLD;
            out_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (!(RETRIGGER && in)) begin
            dropped_q <= in;
            if (cnt_zero) begin
              out_q <= 1'b0;
              if (GAP_CYCLES > 0) begin
                state_q <= GAP;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          dropped_q <= in;
          if (cnt_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed, table-driven bench for pulse_stretcher (HOLD=4, GAP=2) plus a
// GAP_CYCLES=0 instance. Expected values follow PULSE_STRETCHER_RETRIGGER_EN.
module tb_pulse_stretcher;

  typedef struct {
    logic in;
    logic out;
    logic busy;
    logic dropped;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in = 1'b0;
  logic out, busy, dropped;
  logic in0 = 1'b0;
  logic out0, busy0, dropped0;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #10 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .busy(busy), .dropped(dropped)
  );

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .in(in0), .out(out0), .busy(busy0), .dropped(dropped0)
  );

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b expected %b at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic add(input logic i, input logic o, input logic b, input logic d);
    vec_t v;
    v.in = i; v.out = o; v.busy = b; v.dropped = d;
    vecs.push_back(v);
  endtask

  // Drive in between edges, then sample just after the next posedge.
  task automatic step(input logic v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, asserted asynchronously before any clock edge.
    #2 reset = 1'b1;
    #3;
    check("rst_out", 0, out, 1'b0);
    check("rst_busy", 0, busy, 1'b0);
    check("rst_dropped", 0, dropped, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single pulse
    add(1,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(0,0,1,0); add(0,0,0,0); add(0,0,0,0);
    // 2: pulse in GAP rejected
    add(1,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(1,0,1,1); add(0,0,0,0); add(0,0,0,0);
    // 3: second pulse during HOLD
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    add(1,1,1,0); add(0,1,1,0); add(1,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,1,1,0); add(0,0,1,0); add(0,0,1,0); add(0,0,0,0);
`else
    add(1,1,1,0); add(0,1,1,0); add(1,1,1,1); add(0,1,1,0); add(0,0,1,0);
    add(0,0,1,0); add(0,0,0,0); add(0,0,0,0); add(0,0,0,0);
`endif
    // 4: in held high for 14 cycles
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    for (int k = 0; k < 14; k++) add(1,1,1,0);
    add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(0,0,1,0); add(0,0,0,0);
`else
    for (int r = 0; r < 2; r++) begin
      add(1,1,1,0); add(1,1,1,1); add(1,1,1,1); add(1,1,1,1);
      add(1,0,1,1); add(1,0,1,1); add(1,0,0,1);
    end
    add(0,0,0,0); add(0,0,0,0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].in);
      check("out", i, out, vecs[i].out);
      check("busy", i, busy, vecs[i].busy);
      check("dropped", i, dropped, vecs[i].dropped);
    end

    // 5: reset mid-HOLD (with a rejected pulse pending) clears outputs at once.
    step(1'b1);
    step(1'b1);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("pre_rst_dropped", 0, dropped, 1'b0);
`else
    check("pre_rst_dropped", 0, dropped, 1'b1);
`endif
    check("pre_rst_out", 0, out, 1'b1);
    in = 1'b0;
    #3 reset = 1'b1;
    #2;
    check("mid_rst_out", 0, out, 1'b0);
    check("mid_rst_busy", 0, busy, 1'b0);
    check("mid_rst_dropped", 0, dropped, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0);
    check("post_rst_out", 0, out, 1'b0);
    step(1'b1);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_out", k + 1, out, 1'b1);
      check("post_rst_busy", k + 1, busy, 1'b1);
      step(1'b0);
    end
    check("post_rst_fall", 0, out, 1'b0);
    check("post_rst_gap_busy", 0, busy, 1'b1);
    step(1'b0);
    step(1'b0);
    check("post_rst_idle", 0, busy, 1'b0);

    // 6: GAP_CYCLES=0 instance with in held high.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in0 = 1'b1;
      @(posedge clk);
      #1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      check("gap0_out", k, out0, 1'b1);
      check("gap0_busy", k, busy0, 1'b1);
`else
      check("gap0_out", k, out0, (k % 5) != 4);
      check("gap0_busy", k, busy0, (k % 5) != 4);
`endif
    end
    @(negedge clk);
    in0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
